// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared frame geometry and FSM encoding for the SPI register controller
package spi_pkg;

    localparam int FRAME_W   = 32;
    localparam int HDR_W     = 16;
    localparam int DATA_W    = FRAME_W - HDR_W;
    localparam int W_BIT     = 31;
    // Position of the W bit inside the 16-bit header shift register.
    localparam int HDR_W_BIT = W_BIT - DATA_W;
    localparam int ADDR_BITS = HDR_W_BIT;
    localparam int CNT_W     = $clog2(HDR_W);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CMD      = 3'd1,
        ST_RD_FETCH = 3'd2,
        ST_DATA     = 3'd3,
        ST_WR       = 3'd4,
        ST_WAIT_CS  = 3'd5
    } spi_state_t;

endpackage

// File: rtl/spi_sync.sv
// rtl/spi_sync.sv - N-stage synchronizer with rising/falling edge detection
module spi_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES:0]   shift_d;
    logic              prev_q;

    assign shift_d = {sync_q, din};
    assign dout    = sync_q[STAGES-1];
    assign rise    = dout & ~prev_q;
    assign fall    = ~dout & prev_q;

    // Shift the asynchronous input through the flop chain and keep one extra flop for edge history.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= shift_d[STAGES-1:0];
            prev_q <= dout;
        end
    end

endmodule

// File: rtl/spi_reg_ctrl.sv
// rtl/spi_reg_ctrl.sv - SPI mode-0 slave that turns 32-bit frames into register-bank reads and writes
module spi_reg_ctrl
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        spi_sclk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic [15:0] reg_addr,
    output logic [15:0] reg_wdata,
    output logic        reg_wr,
    input  logic [15:0] reg_rdata,
    output logic        busy,
    output logic        frame_err
);

    localparam logic [7:0] SETTLE_N = 8'(SYNC_STAGES + 1);

    logic sclk_lvl_unused, sclk_rise, sclk_fall;
    logic cs_sync, cs_rise, cs_fall;
    logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rstn(rstn), .din(spi_sclk),
        .dout(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rstn(rstn), .din(spi_cs_n),
        .dout(cs_sync), .rise(cs_rise), .fall(cs_fall)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rstn(rstn), .din(spi_mosi),
        .dout(mosi_sync), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    spi_state_t         state, state_d;
    logic [CNT_W-1:0]   bit_cnt;
    logic [HDR_W-1:0]   hdr_sr, hdr_next;
    logic [DATA_W-1:0]  data_sr, data_next, miso_sr;
    logic               wait_cnt, is_write, abort, last_bit;
    logic [7:0]         settle_cnt;
    logic               armed;

    assign last_bit  = (bit_cnt == CNT_W'(HDR_W - 1));
    assign hdr_next  = {hdr_sr[HDR_W-2:0], mosi_sync};
    assign data_next = {data_sr[DATA_W-2:0], mosi_sync};
    assign busy      = (state != ST_IDLE);
    assign reg_wr    = (state == ST_WR);

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state decode; a completing 16th edge wins over a simultaneous cs_n rise.
    always_comb begin
        state_d = state;
        abort   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (armed && cs_fall) state_d = ST_CMD;
            end
            ST_CMD: begin
                if (sclk_rise && last_bit) state_d = hdr_next[HDR_W_BIT] ? ST_DATA : ST_RD_FETCH;
                else if (cs_sync)          abort   = 1'b1;
            end
            ST_RD_FETCH: begin
                if (cs_sync)       abort   = 1'b1;
                else if (wait_cnt) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (sclk_rise && last_bit) state_d = is_write ? ST_WR : ST_WAIT_CS;
                else if (cs_sync)          abort   = 1'b1;
            end
            ST_WR: begin
                state_d = ST_WAIT_CS;
            end
            ST_WAIT_CS: begin
                if (cs_sync) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort) state_d = ST_IDLE;
    end

    // After reset the synchronizers show the idle level before the real bus; only arm once cs_n is truly high.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            settle_cnt <= 8'd0;
            armed      <= 1'b0;
        end else begin
            if (settle_cnt != SETTLE_N) settle_cnt <= settle_cnt + 8'd1;
            if (cs_rise || (settle_cnt == SETTLE_N && cs_sync)) armed <= 1'b1;
        end
    end

    // Shift registers, counters and register-bank outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bit_cnt   <= '0;
            hdr_sr    <= '0;
            data_sr   <= '0;
            miso_sr   <= '0;
            wait_cnt  <= 1'b0;
            is_write  <= 1'b0;
            spi_miso  <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= abort;
            unique case (state)
                ST_IDLE: begin
                    bit_cnt  <= '0;
                    wait_cnt <= 1'b0;
                end
                ST_CMD: begin
                    if (sclk_rise) begin
                        hdr_sr  <= hdr_next;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (last_bit) begin
                            reg_addr <= {{(16 - ADDR_BITS){1'b0}}, hdr_next[ADDR_BITS-1:0]};
                            is_write <= hdr_next[HDR_W_BIT];
                        end
                    end
                end
                ST_RD_FETCH: begin
                    wait_cnt <= 1'b1;
                    if (wait_cnt) begin
                        miso_sr  <= reg_rdata;
                        spi_miso <= reg_rdata[DATA_W-1];
                    end
                end
                ST_DATA: begin
                    if (sclk_rise) begin
                        data_sr <= data_next;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (last_bit && is_write) reg_wdata <= data_next;
                    end
                    // The falling edge that closes the header arrives before any data bit; skip it.
                    if (sclk_fall && bit_cnt != '0 && !is_write) begin
                        miso_sr  <= {miso_sr[DATA_W-2:0], 1'b0};
                        spi_miso <= miso_sr[DATA_W-2];
                    end
                end
                default: ;
            endcase
            if (!(state_d inside {ST_RD_FETCH, ST_DATA}) || is_write) spi_miso <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb/tb_spi_reg_ctrl.sv - scoreboard bench for spi_reg_ctrl with a frame-level reference model
`timescale 1ns/1ps
module tb_spi_reg_ctrl;

    localparam int HALF = 9;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        spi_sclk = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso, reg_wr, busy, frame_err;
    logic [15:0] reg_addr, reg_wdata, reg_rdata;

    always #5 clk = ~clk;

    spi_reg_ctrl #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rstn(rstn),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rdata(reg_rdata),
        .busy(busy), .frame_err(frame_err)
    );

    logic [15:0] bank    [256];
    logic [15:0] ref_mem [256];

    always @(posedge clk) begin
        if (reg_wr) bank[reg_addr[7:0]] <= reg_wdata;
        reg_rdata <= bank[reg_addr[7:0]];
    end

    localparam int EV_WR = 0, EV_RD = 1, EV_ERR = 2;
    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic [15:0] data;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic consume(input ev_t got);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d addr %h data %h, required none", got.kind, got.addr, got.data);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", 32'(got.kind), 32'(e.kind));
            if (e.kind == EV_WR) check("wr_addr", {16'h0, got.addr}, {16'h0, e.addr});
            if (e.kind != EV_ERR) check("data", {16'h0, got.data}, {16'h0, e.data});
        end
    endtask

    // Monitor: every DUT-presented event is matched against the head of the expectation queue.
    always @(negedge clk) begin
        if (rstn) begin
            if (reg_wr)    consume('{kind: EV_WR, addr: reg_addr, data: reg_wdata});
            if (frame_err) consume('{kind: EV_ERR, addr: 16'h0, data: 16'h0});
        end
        while (obs_q.size() > 0) consume(obs_q.pop_front());
    end

    task automatic clk_wait(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic spi_bit(input logic b, input int cs_delay, output logic m);
        spi_mosi = b;
        clk_wait(HALF);
        spi_sclk = 1'b1;
        m = spi_miso;
        if (cs_delay > 0) begin
            clk_wait(cs_delay);
            spi_cs_n = 1'b1;
        end
        clk_wait(HALF);
        spi_sclk = 1'b0;
    endtask

    task automatic do_frame(input logic [31:0] frame, input int nbits, input int cs_delay);
        logic [15:0] addr;
        logic [15:0] rd_word;
        logic        bad;
        logic        m;
        addr    = {1'b0, frame[30:16]};
        rd_word = '0;
        bad     = 1'b0;
        if (nbits < 32)
            exp_q.push_back('{kind: EV_ERR, addr: 16'h0, data: 16'h0});
        else if (frame[31]) begin
            exp_q.push_back('{kind: EV_WR, addr: addr, data: frame[15:0]});
            ref_mem[addr[7:0]] = frame[15:0];
        end else
            exp_q.push_back('{kind: EV_RD, addr: 16'h0, data: ref_mem[addr[7:0]]});
        spi_cs_n = 1'b0;
        clk_wait(HALF);
        for (int i = 0; i < nbits; i++) begin
            spi_bit((i < 32) ? frame[31-i] : 1'($urandom_range(0, 1)), (i == nbits - 1) ? cs_delay : 0, m);
            if (!frame[31] && i >= 16 && i < 32) rd_word = {rd_word[14:0], m};
            else if (m !== 1'b0) bad = 1'b1;
            if (i == 8) check("busy_mid", {31'h0, busy}, 32'h1);
        end
        clk_wait(HALF);
        spi_cs_n = 1'b1;
        clk_wait(6);
        if (nbits >= 32 && !frame[31]) obs_q.push_back('{kind: EV_RD, addr: 16'h0, data: rd_word});
        check("miso_quiet", {31'h0, bad}, 32'h0);
        check("busy_end", {31'h0, busy}, 32'h0);
    endtask

    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic        m;
        logic [31:0] f;
        int          sel, nb;
        for (int i = 0; i < 256; i++) begin
            bank[i]    = 16'(i * 16'h0101) ^ 16'h5A00;
            ref_mem[i] = 16'(i * 16'h0101) ^ 16'h5A00;
        end
        bank[2]    = 16'h0001;
        ref_mem[2] = 16'h0001;

        clk_wait(4);
        check("rst_reg_addr",  {16'h0, reg_addr},  32'h0);
        check("rst_reg_wdata", {16'h0, reg_wdata}, 32'h0);
        check("rst_reg_wr",    {31'h0, reg_wr},    32'h0);
        check("rst_miso",      {31'h0, spi_miso},  32'h0);
        check("rst_busy",      {31'h0, busy},      32'h0);
        check("rst_frame_err", {31'h0, frame_err}, 32'h0);
        rstn = 1'b1;
        clk_wait(6);

        do_frame(32'h8000_0123, 32, 0);
        do_frame(32'h0002_0000, 32, 0);
        do_frame(32'h8004_00AA, 20, 0);
        do_frame(32'h8002_0001, 32, 0);
        do_frame(32'h8004_0001, 32, 0);
        check("hold_addr",  {16'h0, reg_addr},  32'h0004);
        check("hold_wdata", {16'h0, reg_wdata}, 32'h0001);

        // Reset lands at bit 24 of a write; cs_n stays low across the release.
        f = 32'h8007_7777;
        spi_cs_n = 1'b0;
        clk_wait(HALF);
        for (int i = 0; i < 24; i++) spi_bit(f[31-i], 0, m);
        rstn = 1'b0;
        clk_wait(3);
        check("mid_rst_addr",  {16'h0, reg_addr},  32'h0);
        check("mid_rst_wdata", {16'h0, reg_wdata}, 32'h0);
        check("mid_rst_wr",    {31'h0, reg_wr},    32'h0);
        check("mid_rst_busy",  {31'h0, busy},      32'h0);
        check("mid_rst_miso",  {31'h0, spi_miso},  32'h0);
        rstn = 1'b1;
        clk_wait(2);
        for (int i = 24; i < 32; i++) spi_bit(f[31-i], 0, m);
        clk_wait(HALF);
        spi_cs_n = 1'b1;
        clk_wait(6);
        check("post_rst_busy", {31'h0, busy}, 32'h0);

        do_frame(32'h8003_BEEF, 32, 0);
        do_frame(32'h0003_0000, 32, 0);
        do_frame(32'h0007_0000, 32, 0);
        do_frame(32'h8005_1234, 40, 0);
        do_frame(32'h0005_FFFF, 40, 0);
        do_frame(32'h8006_5A5A, 32, 1);
        do_frame(32'h0006_0000, 32, 0);
        do_frame(32'hFFFF_8001, 32, 0);
        do_frame(32'h7FFF_0000, 32, 0);

        for (int k = 0; k < 30; k++) begin
            sel = $urandom_range(0, 9);
            nb  = (sel < 6) ? 32 : (sel < 8) ? 40 : $urandom_range(9, 31);
            f   = {1'($urandom_range(0, 1)), 15'($urandom_range(0, 15)), 16'($urandom)};
            do_frame(f, nb, 0);
        end

        for (int k = 0; k < 200 && exp_q.size() > 0; k++) clk_wait(1);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
